// File: rtl/cache_pkg.sv
// cache_pkg: cache controller state encoding and address-split width helpers.
// S_FLUSH exists only when DCACHE_FLUSH_EN is defined.
package cache_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL
`ifdef DCACHE_FLUSH_EN
        , S_FLUSH
`endif
    } state_t;
    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction
    function automatic int line_addr_w(input int addr_w, input int line_bytes);
        return addr_w - $clog2(line_bytes);
    endfunction
endpackage

// File: rtl/cache_tag_array.sv
// cache_tag_array: per-line valid/dirty/tag storage with a single shared index,
// tag compare, refill set, dirty set/clear and whole-array invalidate.
module cache_tag_array #(
    parameter int NUM_LINES = 4,
    parameter int TAG_W = 26,
    localparam int IDX_W = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] cmp_tag,
    input  logic             set_en,
    input  logic             dirty_set,
    input  logic             dirty_clr,
    input  logic             inval_all,
    output logic             rd_valid,
    output logic             rd_dirty,
    output logic [TAG_W-1:0] rd_tag,
    output logic             hit
);
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q [NUM_LINES];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (inval_all) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (set_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (dirty_set) begin
            dirty_q[index] <= 1'b1;
        end else if (dirty_clr) begin
            dirty_q[index] <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (set_en) tag_q[index] <= cmp_tag;
    end
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign hit      = rd_valid && rd_tag == cmp_tag;
endmodule

// File: rtl/data_cache_param.sv
// data_cache_param: direct-mapped write-back data cache with a line-wide memory port.
// Define DCACHE_FLUSH_EN to add the flush/flush_done ports and the FLUSH walk.
module data_cache_param import cache_pkg::*; #(
    parameter int NUM_LINES  = 4,
    parameter int LINE_BYTES = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       mem_read,
    input  logic                                       mem_write,
    input  logic [ADDR_W-1:0]                          address,
    input  logic [31:0]                                writedata,
    output logic [31:0]                                readdata,
    output logic                                       stall,
    output logic                                       mem_req,
    output logic                                       mem_we,
    output logic [line_addr_w(ADDR_W, LINE_BYTES)-1:0] mem_addr,
    output logic [8*LINE_BYTES-1:0]                    mem_wdata,
    input  logic [8*LINE_BYTES-1:0]                    mem_rdata,
    input  logic                                       mem_ack
`ifdef DCACHE_FLUSH_EN
    ,
    input  logic                                       flush,
    output logic                                       flush_done
`endif
);
    localparam int OFF_W = off_w(LINE_BYTES);
    localparam int LA_W  = line_addr_w(ADDR_W, LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = LA_W - IDX_W;
    localparam int WORDS = LINE_BYTES / 4;
    localparam int WO_W  = WORDS > 1 ? $clog2(WORDS) : 1;

    state_t                 state_q, state_d;
    logic [WORDS-1:0][31:0] data_q [NUM_LINES];
    logic [IDX_W-1:0]       req_idx, idx;
    logic [TAG_W-1:0]       req_tag, v_tag;
    logic [WO_W-1:0]        woff;
    logic                   req, hit, v_valid, v_dirty, victim_dirty;
    logic                   flush_go, fl_wb, fl_last, wb_act, refill_done, store_hit;
    logic                   unused_addr;

    assign req_idx      = address[OFF_W +: IDX_W];
    assign req_tag      = address[ADDR_W-1 -: TAG_W];
    assign woff         = WO_W'(address[ADDR_W-1:2]) & WO_W'(WORDS - 1);
    assign unused_addr  = ^address[1:0];
    assign req          = mem_read || mem_write;
    assign victim_dirty = v_valid && v_dirty;

`ifdef DCACHE_FLUSH_EN
    logic [IDX_W-1:0] fl_idx;
    logic             fl_adv;
    assign flush_go   = flush && state_q == S_IDLE;
    assign fl_wb      = state_q == S_FLUSH && victim_dirty;
    assign fl_adv     = state_q == S_FLUSH && (!victim_dirty || mem_ack);
    assign fl_last    = fl_adv && fl_idx == IDX_W'(NUM_LINES - 1);
    assign flush_done = fl_last;
    assign idx        = state_q == S_FLUSH ? fl_idx : req_idx;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fl_idx <= '0;
        else if (fl_adv) fl_idx <= fl_idx + 1'b1;
    end
`else
    assign flush_go = 1'b0;
    assign fl_wb    = 1'b0;
    assign fl_last  = 1'b0;
    assign idx      = req_idx;
`endif

    cache_tag_array #(.NUM_LINES(NUM_LINES), .TAG_W(TAG_W)) u_tags (
        .clk       (clk),
        .reset     (reset),
        .index     (idx),
        .cmp_tag   (req_tag),
        .set_en    (refill_done),
        .dirty_set (store_hit),
        .dirty_clr (wb_act && mem_ack),
        .inval_all (fl_last),
        .rd_valid  (v_valid),
        .rd_dirty  (v_dirty),
        .rd_tag    (v_tag),
        .hit       (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = (req && !hit) ? (victim_dirty ? S_WRITEBACK : S_REFILL) : S_IDLE;
            S_WRITEBACK: state_d = mem_ack ? S_REFILL : S_WRITEBACK;
            S_REFILL:    state_d = mem_ack ? S_IDLE : S_REFILL;
`ifdef DCACHE_FLUSH_EN
            S_FLUSH:     state_d = fl_last ? S_IDLE : S_FLUSH;
`endif
            default:     state_d = S_IDLE;
        endcase
`ifdef DCACHE_FLUSH_EN
        if (flush_go) state_d = S_FLUSH;
`endif
    end

    // Lines are invalid while reset is low, so hits and refills cannot touch data then.
    assign refill_done = state_q == S_REFILL && mem_ack;
    assign store_hit   = state_q == S_IDLE && !flush_go && mem_write && hit;
    always_ff @(posedge clk) begin
        if (refill_done) data_q[req_idx] <= mem_rdata;
        else if (store_hit) data_q[req_idx][woff] <= writedata;
    end

    assign wb_act    = state_q == S_WRITEBACK || fl_wb;
    assign mem_req   = wb_act || state_q == S_REFILL;
    assign mem_we    = wb_act;
    assign mem_addr  = wb_act ? {v_tag, idx} : state_q == S_REFILL ? address[ADDR_W-1:OFF_W] : '0;
    assign mem_wdata = wb_act ? data_q[idx] : '0;
    assign stall     = reset && (state_q != S_IDLE || flush_go || (req && !hit));
    assign readdata  = reset ? data_q[req_idx][woff] : '0;
endmodule

// File: tb/tb_data_cache_param.sv
// tb_data_cache_param: directed and random loads/stores against a line-level cache model.
module tb_data_cache_param;
    logic         clk = 1'b0, reset = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_ack = 1'b0;
    logic         mem_req, mem_we, stall;
    logic [31:0]  address = '0, writedata = '0, readdata;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata = '0;
`ifdef DCACHE_FLUSH_EN
    logic         flush = 1'b0, flush_done;
`endif
    int           n_chk = 0, n_fail = 0;
    bit           m_valid [4], m_dirty [4];
    logic [27:0]  m_la [4];
    logic [127:0] m_data [4];
    logic [127:0] mem [logic [27:0]];

    always #5 clk = ~clk;

    data_cache_param dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_FLUSH_EN
        ,
        .flush     (flush),
        .flush_done(flush_done)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] backing(input logic [27:0] la);
        logic [127:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = (32'(la) * 4 + 32'(w)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // One memory transfer: lat wait cycles, then an ack cycle; fields checked every cycle.
    task automatic xfer(input bit we, input logic [27:0] la, input logic [127:0] wd,
                        input logic [127:0] rd, input int lat, inout int stalls);
        for (int c = 0; c <= lat; c++) begin
            mem_ack   = (c == lat);
            mem_rdata = (c == lat) ? rd : {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk(we ? "wb_req" : "rf_req", mem_req, 1);
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, la);
            if (we) chk("mem_wdata", mem_wdata, wd);
            stalls += int'(stall);
            tick();
        end
        mem_ack = 1'b0;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input int lat_wb, input int lat_rf, input string tag);
        logic [27:0] la;
        int idx, w, stalls, exp_st;
        bit hit;
        la     = a[31:4];
        idx    = int'(la[1:0]);
        w      = int'(a[3:2]);
        stalls = 0;
        exp_st = 0;
        hit    = m_valid[idx] && m_la[idx] == la;
        mem_read  = rd;
        mem_write = wr;
        address   = a;
        writedata = wd;
        if (!hit) begin
            mem_ack = 1'b0;
            #1;
            chk({tag, "_idle_req"}, mem_req, 0);
            stalls += int'(stall);
            exp_st = 1;
            tick();
            if (m_valid[idx] && m_dirty[idx]) begin
                xfer(1'b1, m_la[idx], m_data[idx], '0, lat_wb, stalls);
                mem[m_la[idx]] = m_data[idx];
                exp_st += lat_wb + 1;
            end
            m_data[idx] = backing(la);
            xfer(1'b0, la, '0, m_data[idx], lat_rf, stalls);
            exp_st += lat_rf + 1;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_la[idx]    = la;
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
        end
        #1;
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_stall_cycles"}, exp_st, stalls);
        chk({tag, "_hit_req"}, mem_req, 0);
        if (wr) begin
            m_data[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end else begin
            chk({tag, "_rdata"}, readdata, m_data[idx][w*32 +: 32]);
        end
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_ack   = 1'b0;
    endtask

    task automatic idle_cycle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        #1;
        chk("idle_stall", stall, 0);
        chk("idle_req", mem_req, 0);
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        model_clear();
    endtask

    initial begin
        int r;
        logic [31:0] a;
        // Reset state with a load pending on the bus
        mem_read = 1'b1;
        address  = 32'h40;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_readdata", readdata, 0);
        @(negedge clk);
        mem_read = 1'b0;
        reset    = 1'b1;
        model_clear();

        // Cold miss, memory answers in the third refill cycle: four stall cycles
        mem[28'h4] = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'hDEAD_BEEF};
        access(1'b1, 1'b0, 32'h40, '0, 0, 2, "cold");
        access(1'b0, 1'b1, 32'h44, 32'h1234_5678, 0, 0, "st44");
        access(1'b1, 1'b0, 32'h44, '0, 0, 0, "ld44");
        // Dirty victim at index 0 forces a writeback of line 0x4 then a refill of 0x10
        access(1'b1, 1'b0, 32'h100, '0, 1, 1, "evict");
        access(1'b1, 1'b0, 32'h44, '0, 0, 0, "reload44");

        for (int i = 0; i < 160; i++) begin
            r = int'($urandom_range(0, 9));
            a = {22'd0, 6'($urandom_range(0, 11)), 4'($urandom)};
            if (r == 0) idle_cycle();
            else access(r < 6 || r == 9, r >= 6, a, $urandom,
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "rnd");
        end

        // Reset in the middle of a refill; the late ack must be ignored
        do_reset();
        mem_read = 1'b1;
        address  = 32'h40;
        tick();
        #1;
        chk("mid_refill_req", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_rdata", readdata, 0);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = {4{32'hBAD0_BAD0}};
        tick();
        mem_ack  = 1'b0;
        mem_read = 1'b0;
        reset    = 1'b1;
        model_clear();
        access(1'b1, 1'b0, 32'h40, '0, 0, 1, "after_rst");

`ifdef DCACHE_FLUSH_EN
        begin
            int wbs, dones;
            do_reset();
            access(1'b0, 1'b1, 32'h14, 32'hAAAA_0001, 0, 0, "fl_st1");
            access(1'b0, 1'b1, 32'h38, 32'hBBBB_0003, 0, 0, "fl_st3");
            access(1'b1, 1'b0, 32'h20, '0, 0, 0, "fl_ld2");
            access(1'b1, 1'b0, 32'h00, '0, 0, 0, "fl_ld0");
            wbs   = 0;
            dones = 0;
            flush = 1'b1;
            for (int c = 0; c < 40 && dones == 0; c++) begin
                #1;
                chk("fl_stall", stall, 1);
                if (mem_req) begin
                    chk("fl_we", mem_we, 1);
                    if (wbs < 2) begin
                        chk("fl_addr", mem_addr, m_la[wbs == 0 ? 1 : 3]);
                        chk("fl_wdata", mem_wdata, m_data[wbs == 0 ? 1 : 3]);
                    end
                    wbs++;
                    mem_ack = 1'b1;
                    #1;
                end
                dones += int'(flush_done);
                tick();
                mem_ack = 1'b0;
                flush   = 1'b0;
            end
            chk("fl_writebacks", wbs, 2);
            chk("fl_done_pulses", dones, 1);
            #1;
            chk("fl_done_low", flush_done, 0);
            chk("fl_after_stall", stall, 0);
            tick();
            mem[m_la[1]] = m_data[1];
            mem[m_la[3]] = m_data[3];
            model_clear();
            access(1'b1, 1'b0, 32'h14, '0, 0, 1, "fl_miss1");
            access(1'b1, 1'b0, 32'h00, '0, 0, 0, "fl_miss0");
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
